fetch_ctrl: RTL
===============

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameter: RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Port: clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 Port: rstn_i  input  1  reset, asynchronous and active-low.
REQ-004 Port: mem_req_o  output  1  instruction-memory read request.
REQ-005 Port: mem_addr_o  output  32  read byte address; equals pc_q.
REQ-006 Port: mem_gnt_i  input  1  request accepted this cycle.
REQ-007 Port: mem_rvalid_i  input  1  read data valid; exactly one response per granted request, in order.
REQ-008 Port: mem_rdata_i  input  32  raw little-endian instruction word.
REQ-009 Port: instr_o  output  32  latched raw word driven to the decoder's mem_data_i.
REQ-010 Port: dec_enable_o  output  1  instr_o valid; drives the decoder's enable_i.
REQ-011 Port: dec_ready_i  input  1  downstream consumes instr_o this cycle.
REQ-012 Port: redirect_i  input  1  single-cycle PC redirect (branch, jump, trap).
REQ-013 Port: redirect_pc_i  input  32  redirect target.
REQ-014 Port: pc_o  output  32  address of the word currently on instr_o.
REQ-015 Port: fault_o  output  1  misaligned fetch target; high while in FAULT.

Function
REQ-016 The FSM SHALL have states REQ, WAIT, HOLD, DRAIN and FAULT, one-hot or binary.
REQ-017 REQ: mem_req_o=1, mem_addr_o=pc_q; mem_gnt_i=1 -> WAIT; else stay in REQ with address stable.
REQ-018 WAIT: mem_rvalid_i=1 -> instr_o<=mem_rdata_i, pc_o<=pc_q, pc_q<=pc_q+4 (mod 2^32, wrap 32'hFFFF_FFFC->0), -> HOLD.
REQ-019 HOLD: dec_enable_o=1; instr_o and pc_o stable; dec_ready_i=1 -> REQ; else stay in HOLD.
REQ-020 dec_enable_o SHALL be 1 only in HOLD; mem_req_o SHALL be 1 only in REQ.
REQ-021 Minimum latency: request granted on cycle N, rvalid on N+1, dec_enable_o high on N+2; with dec_ready_i=1, the next mem_req_o is on N+3.
REQ-022 redirect_i SHALL load pc_q<=redirect_pc_i and take priority over every other transition.
REQ-023 Redirect in REQ with mem_gnt_i=0 -> REQ; the new address appears on the next cycle.
REQ-024 Redirect in REQ with mem_gnt_i=1 -> DRAIN; the stale response is owed.
REQ-025 Redirect in WAIT with mem_rvalid_i=1 -> REQ; the response is discarded and instr_o is not updated.
REQ-026 Redirect in WAIT with mem_rvalid_i=0 -> DRAIN.
REQ-027 Redirect in HOLD -> REQ; dec_enable_o drops the next cycle even if dec_ready_i=1 in the same cycle.
REQ-028 Redirect in DRAIN or FAULT updates pc_q and leaves the outstanding-response handling unchanged.
REQ-029 DRAIN: mem_req_o=0; mem_rvalid_i=1 -> discard the data and go to REQ; instr_o is never loaded from a drained response.
REQ-030 Any transition into REQ with pc_q[1:0]!=2'b00 SHALL enter FAULT instead.
REQ-031 FAULT: fault_o=1, mem_req_o=0, dec_enable_o=0; exit only via a redirect with an aligned target -> REQ.
REQ-032 A redirect with a misaligned target in FAULT SHALL keep the block in FAULT.
REQ-033 At most one memory request SHALL be outstanding at any time.

Reset
REQ-034 rstn_i low SHALL immediately force: state=REQ, pc_q=RESET_PC, instr_o=0, pc_o=0, dec_enable_o=0, fault_o=0.
REQ-035 mem_req_o SHALL be held 0 while rstn_i is low; it is asserted on the first edge after rstn_i deasserts.
REQ-036 Reset asserted mid-transaction SHALL abandon any outstanding response; the memory model is reset in the same cycle.

Verification
REQ-037 Reset release, RESET_PC=0, gnt and rvalid after 1 cycle, dec_ready_i=1 -> addresses 0, 4, 8 issued; instr_o/pc_o match; one instruction per 3 cycles.
REQ-038 dec_ready_i=0 for 5 cycles in HOLD -> instr_o stable, dec_enable_o=1, no mem_req_o; the next request is issued 1 cycle after dec_ready_i rises.
REQ-039 Redirect to 32'h100 in WAIT, rvalid 2 cycles later -> that data is dropped, the next request is to 32'h100, and instr_o is never updated with the stale word.
REQ-040 Redirect to 32'h102 -> fault_o=1, no requests; then redirect to 32'h200 -> fault_o=0, request to 32'h200.
REQ-041 pc_q=32'hFFFF_FFFC fetch completes -> the next address is 32'h0000_0000.
REQ-042 rstn_i low while in WAIT -> all outputs return to reset values asynchronously; after release, the first request is to RESET_PC.

Source files
------------

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
// Instruction fetch sequencer. Issues one read at a time to instruction memory,
// latches the returned word for the decoder and holds it until consumed.
// Redirects (branch/jump/trap) reload the PC at any time. Responses that are
// still owed for abandoned requests are drained and discarded. A misaligned
// fetch target parks the block in FAULT until an aligned redirect arrives.
//
// Ports
//   clk_i, rstn_i          clock, asynchronous active-low reset
//   mem_req_o/mem_addr_o   read request and byte address (address = pc_q)
//   mem_gnt_i              request accepted this cycle
//   mem_rvalid_i/rdata_i   in-order read response, one per grant
//   instr_o/pc_o           latched word and its address
//   dec_enable_o           instr_o valid (HOLD only)
//   dec_ready_i            decoder consumes instr_o this cycle
//   redirect_i/_pc_i       single-cycle PC reload
//   fault_o                misaligned fetch target
//
// state   | meaning
// S_REQ   | request on the bus, waiting for grant
// S_WAIT  | granted, waiting for the response
// S_HOLD  | word presented to the decoder
// S_DRAIN | discarding a response owed to an abandoned request
// S_FAULT | misaligned target, waiting for an aligned redirect
// -----------------------------------------------------------------------------
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i,
    output logic [31:0] instr_o,
    output logic        dec_enable_o,
    input  logic        dec_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [31:0] pc_o,
    output logic        fault_o
);

    typedef enum logic [2:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN,
        S_FAULT
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic [31:0] pco_q, pco_d;
    // Keeps the request low until the first clock edge after reset release.
    logic        run_q;
    logic        granted;

    assign granted = run_q && mem_gnt_i;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        pco_d   = pco_q;

        case (state_q)
            S_REQ:   if (granted) state_d = S_WAIT;
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    instr_d = mem_rdata_i;
                    pco_d   = pc_q;
                    pc_d    = pc_q + 32'd4;
                    state_d = S_HOLD;
                end
            end
            S_HOLD:  if (dec_ready_i) state_d = S_REQ;
            S_DRAIN: if (mem_rvalid_i) state_d = S_REQ;
            default: ;
        endcase

        // Redirect overrides the normal transition; the only thing it must not
        // disturb is tracking of a response that is still owed.
        if (redirect_i) begin
            pc_d = redirect_pc_i;
            case (state_q)
                S_REQ:   state_d = granted ? S_DRAIN : S_REQ;
                S_WAIT: begin
                    instr_d = instr_q;
                    pco_d   = pco_q;
                    state_d = mem_rvalid_i ? S_REQ : S_DRAIN;
                end
                S_HOLD:  state_d = S_REQ;
                S_FAULT: state_d = S_REQ;
                default: ;
            endcase
        end

        if (state_d == S_REQ && pc_d[1:0] != 2'b00) state_d = S_FAULT;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q <= S_REQ;
            pc_q    <= RESET_PC;
            instr_q <= 32'h0;
            pco_q   <= 32'h0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            pco_q   <= pco_d;
            run_q   <= 1'b1;
        end
    end

    assign mem_req_o    = run_q && (state_q == S_REQ);
    assign mem_addr_o   = pc_q;
    assign instr_o      = instr_q;
    assign pc_o         = pco_q;
    assign dec_enable_o = (state_q == S_HOLD);
    assign fault_o      = (state_q == S_FAULT);

endmodule
